e_stage_mdu: RTL and testbench

// - Multi-cycle multiply/divide unit for the E stage; sits beside the combinational ALU and owns the HI/LO registers.
// - Runs mult/multu/div/divu with a fixed, parametrised latency.
// - Raises busy so the hazard unit stalls D-stage MD instructions.
// - Supports mthi/mtlo writes and exposes HI/LO for mfhi/mflo reads.

---
 rtl/e_stage_mdu.sv | 160 ++++++++++++++++
 tb/tb_e_stage_mdu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/e_stage_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/multu/div/divu that owns HI/LO, plus mthi/mtlo.
// Optional madd (op 7) is enabled with `define E_STAGE_MDU_MADD_EN.
module e_stage_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             sgn_q, sgn_d;
    logic             dz_q, dz_d;
`ifdef E_STAGE_MDU_MADD_EN
    logic             madd_q, madd_d;
`endif

    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH-1:0]   a_mag, b_mag, b_div, q_u, r_u, quot, rem;
    logic               a_neg, b_neg;

    // One multiplier serves both signednesses: a 2W-bit product of extended operands is exact mod 2^2W.
    always_comb begin
        a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
        b_ext = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
        prod  = a_ext * b_ext;
`ifdef E_STAGE_MDU_MADD_EN
        if (madd_q) prod = prod + {hi_q, lo_q};
`endif
        a_neg = sgn_q & a_q[WIDTH-1];
        b_neg = sgn_q & b_q[WIDTH-1];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
        b_div = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_u   = a_mag / b_div;
        r_u   = a_mag % b_div;
        // Most-negative / -1 falls out naturally: magnitude quotient 2^(W-1) negates to itself.
        quot  = (a_neg ^ b_neg) ? -q_u : q_u;
        rem   = a_neg ? -r_u : r_u;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sgn_d   = sgn_q;
        dz_d    = dz_q;
`ifdef E_STAGE_MDU_MADD_EN
        madd_d  = madd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd1, 3'd2: begin
                            a_d     = a;
                            b_d     = b;
                            sgn_d   = (md_op == 3'd1);
                            cnt_d   = MUL_LD;
                            state_d = S_MUL;
`ifdef E_STAGE_MDU_MADD_EN
                            madd_d  = 1'b0;
`endif
                        end
                        3'd3, 3'd4: begin
                            a_d     = a;
                            b_d     = b;
                            sgn_d   = (md_op == 3'd3);
                            cnt_d   = DIV_LD;
                            state_d = S_DIV;
                        end
                        3'd5: hi_d = a;
                        3'd6: lo_d = a;
`ifdef E_STAGE_MDU_MADD_EN
                        3'd7: begin
                            a_d     = a;
                            b_d     = b;
                            sgn_d   = 1'b1;
                            madd_d  = 1'b1;
                            cnt_d   = MUL_LD;
                            state_d = S_MUL;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (state_q == S_MUL) begin
                        {hi_d, lo_d} = prod;
                    end else if (b_q == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                        dz_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            dz_q    <= 1'b0;
`ifdef E_STAGE_MDU_MADD_EN
            madd_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            dz_q    <= dz_d;
`ifdef E_STAGE_MDU_MADD_EN
            madd_q  <= madd_d;
`endif
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;
endmodule

// File: tb/tb_e_stage_mdu.sv
// Bench for e_stage_mdu: directed vector table, hand sequences for reset/ignore, random ops vs. arithmetic model.
module tb_e_stage_mdu;
    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;
    logic        div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi, m_lo;
    logic        m_dz;

    e_stage_mdu #(.WIDTH(32), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .reset(rst_n), .start(start), .md_op(md_op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int op_lat(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MULC;
        if (op == 3'd3 || op == 3'd4) return DIVC;
`ifdef E_STAGE_MDU_MADD_EN
        if (op == 3'd7) return MULC;
`endif
        return 0;
    endfunction

    // Reference: results derived straight from the ISA arithmetic rules.
    task automatic model_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        longint          sp;
        longint unsigned up;
        int              sq, sr;
        case (op)
            3'd1: begin sp = longint'($signed(av)) * longint'($signed(bv)); {m_hi, m_lo} = sp; end
            3'd2: begin up = longint'({32'd0, av}) * longint'({32'd0, bv}); {m_hi, m_lo} = up; end
            3'd3, 3'd4: begin
                if (bv == 32'd0) m_dz = 1'b1;
                else begin
                    m_dz = 1'b0;
                    if (op == 3'd4) begin m_lo = av / bv; m_hi = av % bv; end
                    else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin m_lo = av; m_hi = 32'd0; end
                    else begin
                        sq = $signed(av) / $signed(bv);
                        sr = $signed(av) % $signed(bv);
                        m_lo = sq; m_hi = sr;
                    end
                end
            end
            3'd5: m_hi = av;
            3'd6: m_lo = av;
`ifdef E_STAGE_MDU_MADD_EN
            3'd7: begin
                sp = longint'({m_hi, m_lo}) + longint'($signed(av)) * longint'($signed(bv));
                {m_hi, m_lo} = sp;
            end
`endif
            default: ;
        endcase
    endtask

    // Called #1 after a rising edge; leaves at #1 after the edge where the result should be visible.
    task automatic do_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input int lat, input logic [31:0] old_hi, input logic [31:0] old_lo,
                         output int bcnt);
        start = 1'b1; md_op = op; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0; a = $urandom; b = $urandom;
        bcnt = 0;
        for (int k = 0; k < lat; k++) begin
            if (busy) bcnt++;
            if (k == lat - 1) begin
                check("early_hi", hi, old_hi);
                check("early_lo", lo, old_lo);
            end
            @(posedge clk); #1;
        end
        if (busy) bcnt++;
    endtask

    initial begin
        int bcnt;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [31:0] oh, ol;

        rst_n = 1'b0; start = 1'b0; md_op = 3'd0; a = '0; b = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // Async reset in the middle of a multiply must wipe HI/LO and never write afterwards.
        do_op(3'd5, 32'h55, 32'd0, 0, 32'd0, 32'd0, bcnt);
        do_op(3'd6, 32'h66, 32'd0, 0, 32'd0, 32'd0, bcnt);
        check("pre_rst_hi", hi, 32'h55);
        start = 1'b1; md_op = 3'd1; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < MULC + 2; k++) begin @(posedge clk); #1; end
        check("postrst_hi", hi, 32'd0);
        check("postrst_lo", lo, 32'd0);
        check("postrst_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0;

        vecs.push_back('{3'd1, 32'hFFFF_FFFE, 32'd3, MULC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0});
        vecs.push_back('{3'd2, 32'hFFFF_FFFE, 32'd3, MULC, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0});
        vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'd2, DIVC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{3'd4, 32'd7,         32'd2, DIVC, 32'd1,        32'd3,        1'b0});
        vecs.push_back('{3'd5, 32'h11,        32'd0, 0,    32'h11,       32'd3,        1'b0});
        vecs.push_back('{3'd6, 32'h22,        32'd0, 0,    32'h11,       32'h22,       1'b0});
        vecs.push_back('{3'd3, 32'd100,       32'd0, DIVC, 32'h11,       32'h22,       1'b1});
        vecs.push_back('{3'd1, 32'd2,         32'd2, MULC, 32'd0,        32'd4,        1'b1});
        vecs.push_back('{3'd4, 32'd9,         32'd3, DIVC, 32'd0,        32'd3,        1'b0});
        vecs.push_back('{3'd0, 32'hDEAD,      32'd1, 0,    32'd0,        32'd3,        1'b0});
        vecs.push_back('{3'd6, 32'd10,        32'd0, 0,    32'd0,        32'd10,       1'b0});
`ifdef E_STAGE_MDU_MADD_EN
        vecs.push_back('{3'd7, 32'd3,         32'd4, MULC, 32'd0,        32'd22,       1'b0});
`else
        vecs.push_back('{3'd7, 32'd3,         32'd4, 0,    32'd0,        32'd10,       1'b0});
`endif
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, MULC, 32'h4000_0000, 32'd0, 1'b0});

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, m_hi, m_lo, bcnt);
            check($sformatf("v%0d_busy", i), bcnt, vecs[i].lat);
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            check($sformatf("v%0d_dz", i), {31'd0, div_zero}, {31'd0, vecs[i].exp_dz});
            m_hi = vecs[i].exp_hi; m_lo = vecs[i].exp_lo; m_dz = vecs[i].exp_dz;
        end

        // Overflow divide with mtlo and mult pulses while busy; both must be ignored.
        start = 1'b1; md_op = 3'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0; a = '0; b = '0;
        bcnt = 0;
        for (int k = 0; k < DIVC; k++) begin
            if (busy) bcnt++;
            start = (k == 2) || (k == 4);
            md_op = (k == 2) ? 3'd6 : 3'd1;
            a     = (k == 2) ? 32'd5 : 32'd7;
            b     = 32'd9;
            @(posedge clk); #1;
            start = 1'b0; md_op = 3'd0;
        end
        if (busy) bcnt++;
        check("ovf_busy", bcnt, DIVC);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);
        check("ovf_dz", {31'd0, div_zero}, 32'd0);
        @(posedge clk); #1;
        check("ovf_after_busy", {31'd0, busy}, 32'd0);
        check("ovf_after_lo", lo, 32'h8000_0000);
        m_hi = 32'd0; m_lo = 32'h8000_0000; m_dz = 1'b0;

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 4) == 0) rb = 32'd0;
            if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            oh = m_hi; ol = m_lo;
            do_op(rop, ra, rb, op_lat(rop), oh, ol, bcnt);
            model_op(rop, ra, rb);
            check($sformatf("r%0d_op%0d_busy", i, rop), bcnt, op_lat(rop));
            check($sformatf("r%0d_op%0d_hi", i, rop), hi, m_hi);
            check($sformatf("r%0d_op%0d_lo", i, rop), lo, m_lo);
            check($sformatf("r%0d_op%0d_dz", i, rop), {31'd0, div_zero}, {31'd0, m_dz});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
